fg_prog_sequencer: RTL and testbench

//  Sequences floating-gate programming of one VMM-WTA island (4x2 indirect array + WTA column).

---
 rtl/fg_prog_pkg.sv | 26 ++
 rtl/fg_pulse_timer.sv | 25 ++
 rtl/fg_prog_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_prog_pkg.sv
// Shared opcode/state encodings and default widths for the floating-gate programming sequencer.
// No logic; FG_PROG_READBACK_EN only decides whether ST_MEASURE is ever reached.
package fg_prog_pkg;
  localparam int ROW_AW_DEF     = 2;
  localparam int COL_AW_DEF     = 3;
  localparam int CNT_W_DEF      = 16;
  localparam int NPULSE_W_DEF   = 8;
  localparam int SETTLE_CYC_DEF = 32;

  typedef enum logic [1:0] {
    OP_INJECT = 2'd0,
    OP_TUNNEL = 2'd1,
    OP_READ   = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_HOLD,
    ST_MEASURE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/fg_pulse_timer.sv
// Load/count-down timer shared by settle, pulse and gap phases; zero is registered-state decode.
// A load of N makes zero rise N cycles later, so a phase loaded with N-1 lasts N cycles.
module fg_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate program sequencer for one VMM-WTA island; one command in flight, cmd_ready only in IDLE.
// Done lands 2*SETTLE_CYC+2 cycles after a 1x1-cycle inject; FG_PROG_READBACK_EN adds a MEASURE handshake.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int ROW_AW     = ROW_AW_DEF,
  parameter int COL_AW     = COL_AW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NPULSE_W   = NPULSE_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ROW_AW-1:0]        cmd_row,
  input  logic [COL_AW-1:0]        cmd_col,
  input  logic [NPULSE_W-1:0]      cmd_npulse,
  input  logic [CNT_W-1:0]         cmd_pw,
  input  logic [CNT_W-1:0]         cmd_gap,
  input  logic                     abort,
  output logic [ROW_AW-1:0]        row_addr,
  output logic [COL_AW-1:0]        col_addr,
  output logic [(1<<ROW_AW)-1:0]   drain_sel,
  output logic                     prog_mode,
  output logic                     inj_en,
  output logic                     tun_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err
`ifdef FG_PROG_READBACK_EN
  ,
  output logic                     meas_req,
  input  logic                     meas_ack,
  input  logic [15:0]              meas_data,
  output logic [15:0]              rd_data,
  output logic                     rd_valid
`endif
);
  localparam int DRAIN_W = 1 << ROW_AW;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);

  state_e               state, state_n, hold_exit;
  op_e                  op_q, op_in;
  logic [CNT_W-1:0]     pw_q, gap_q, pw_m1, gap_m1, load_val;
  logic [NPULSE_W-1:0]  pulses_left;
  logic                 err_q, kill, accept, load, zero;

  assign op_in  = op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;
  // A latched abort (taken together with the accept) still forces the safe exit.
  assign kill   = abort || err_q;
  assign pw_m1  = (pw_q == '0) ? '0 : pw_q - CNT_W'(1);
  assign gap_m1 = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);

  always_comb begin
    hold_exit = ST_DONE;
`ifdef FG_PROG_READBACK_EN
    if (!err_q && !abort && op_q != OP_TUNNEL) hold_exit = ST_MEASURE;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_n = (op_in == OP_RSVD) ? ST_DONE : ST_SETUP;
      ST_SETUP: begin
        if (kill)      state_n = ST_HOLD;
        else if (zero) state_n = (op_q == OP_READ) ? ST_HOLD : ST_PULSE;
      end
      ST_PULSE: begin
        if (kill)      state_n = ST_HOLD;
        else if (zero) state_n = (pulses_left <= NPULSE_W'(1)) ? ST_HOLD : ST_GAP;
      end
      ST_GAP: begin
        if (kill)      state_n = ST_HOLD;
        else if (zero) state_n = ST_PULSE;
      end
      ST_HOLD:  if (zero) state_n = hold_exit;
`ifdef FG_PROG_READBACK_EN
      ST_MEASURE: if (abort || meas_ack) state_n = ST_DONE;
`endif
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = (state_n != state);
    load_val = '0;
    case (state_n)
      ST_SETUP, ST_HOLD: load_val = SETTLE_M1;
      ST_PULSE:          load_val = pw_m1;
      ST_GAP:            load_val = gap_m1;
      default:           load_val = '0;
    endcase
  end

  fg_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_INJECT;
      err_q       <= 1'b0;
      row_addr    <= '0;
      col_addr    <= '0;
      pw_q        <= '0;
      gap_q       <= '0;
      pulses_left <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op_in;
        err_q <= (op_in == OP_RSVD) || abort;
        // Reserved ops leave the decoders untouched.
        if (op_in != OP_RSVD) begin
          row_addr    <= cmd_row;
          col_addr    <= cmd_col;
          pw_q        <= cmd_pw;
          gap_q       <= cmd_gap;
          pulses_left <= (cmd_npulse == '0) ? NPULSE_W'(1) : cmd_npulse;
        end
      end else if (abort && prog_mode) begin
        err_q <= 1'b1;
      end
      if (state == ST_PULSE && state_n == ST_GAP) pulses_left <= pulses_left - NPULSE_W'(1);
    end
  end

`ifdef FG_PROG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == ST_MEASURE) && meas_ack && !abort;
      if ((state == ST_MEASURE) && meas_ack && !abort) rd_data <= meas_data;
    end
  end

  assign meas_req = (state == ST_MEASURE);
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_DONE) && err_q;
  assign prog_mode = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_GAP) ||
                     (state == ST_HOLD)  || (state == ST_MEASURE);
  assign drain_sel = (prog_mode && op_q != OP_TUNNEL) ? (DRAIN_W'(1) << row_addr) : '0;
  assign inj_en    = (state == ST_PULSE) && (op_q == OP_INJECT);
  assign tun_en    = (state == ST_PULSE) && (op_q == OP_TUNNEL);
endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Scenario bench for fg_prog_sequencer: per-command expectations queued at send, popped at done.
module tb_fg_prog_sequencer;
  import fg_prog_pkg::*;

  localparam int S = 32;
`ifdef FG_PROG_READBACK_EN
  localparam int MEAS = 5;
`else
  localparam int MEAS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, abort;
  logic [1:0]  cmd_op, row_addr, cmd_row;
  logic [2:0]  cmd_col, col_addr;
  logic [7:0]  cmd_npulse;
  logic [15:0] cmd_pw, cmd_gap;
  logic [3:0]  drain_sel;
  logic        prog_mode, inj_en, tun_en, busy, done, err;
`ifdef FG_PROG_READBACK_EN
  logic        meas_req, meas_ack, rd_valid;
  logic [15:0] meas_data, rd_data;
`endif

  always #5 clk = ~clk;

  fg_prog_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_npulse(cmd_npulse), .cmd_pw(cmd_pw),
    .cmd_gap(cmd_gap), .abort(abort), .row_addr(row_addr), .col_addr(col_addr),
    .drain_sel(drain_sel), .prog_mode(prog_mode), .inj_en(inj_en), .tun_en(tun_en),
    .busy(busy), .done(done), .err(err)
`ifdef FG_PROG_READBACK_EN
    , .meas_req(meas_req), .meas_ack(meas_ack), .meas_data(meas_data),
    .rd_data(rd_data), .rd_valid(rd_valid)
`endif
  );

  typedef struct {
    int lat; logic err; int inj_n; int inj_len; int tun_n; int tun_len; int gap;
    logic [3:0] drain; logic rd_vld;
  } exp_t;

  typedef struct {
    int lat; logic err; int inj_n; int imin; int imax; int tun_n; int tmin; int tmax;
    int gmin; int gmax; logic [3:0] drain; logic rd_vld; logic [15:0] rd;
    logic both; logic moved; logic stray; logic prog; logic timeout; logic ready_after;
  } obs_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [1:0] op, input int row, input int np, input int pw,
                                 input int gap, input int abort_at, input logic ab);
    exp_t e;
    int npe, pwe, gpe;
    e = '{lat:0, err:1'b0, inj_n:0, inj_len:-1, tun_n:0, tun_len:-1, gap:-1, drain:4'b0, rd_vld:1'b0};
    npe = (np == 0) ? 1 : np;
    pwe = (pw == 0) ? 1 : pw;
    gpe = (gap == 0) ? 1 : gap;
    if (op == 2'd3) begin
      e.lat = 1; e.err = 1'b1;
      return e;
    end
    if (op != 2'd1) e.drain = 4'b0001 << row;
    if (ab) begin
      e.lat = S + 2; e.err = 1'b1;
    end else if (op == 2'd2) begin
      e.lat = 2 * S + MEAS + 1; e.rd_vld = (MEAS > 0);
    end else if (abort_at > 0) begin
      e.lat = 2 * S + abort_at + 1; e.err = 1'b1; e.inj_n = 1; e.inj_len = abort_at;
    end else begin
      e.lat = 2 * S + npe * pwe + (npe - 1) * gpe + 1 + ((op == 2'd0) ? MEAS : 0);
      if (op == 2'd0) begin e.inj_n = npe; e.inj_len = pwe; end
      else begin e.tun_n = npe; e.tun_len = pwe; end
      if (npe > 1) e.gap = gpe;
    end
    return e;
  endfunction

  task automatic send(input logic [1:0] op, input int row, input int col, input int np,
                      input int pw, input int gap, input int abort_at, input logic ab);
    @(posedge clk); #1;
    cmd_op = op; cmd_row = row[1:0]; cmd_col = col[2:0]; cmd_npulse = np[7:0];
    cmd_pw = pw[15:0]; cmd_gap = gap[15:0]; cmd_valid = 1'b1; abort = ab;
    exp_q.push_back(model(op, row, np, pw, gap, abort_at, ab));
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic observe(input int abort_at, output obs_t o);
    int ri = 0, rt = 0, rl = 0, req = 0;
    logic seen = 1'b0;
    logic [1:0] ra; logic [2:0] ca; logic [3:0] ds;
    o = '{lat:0, err:1'b0, inj_n:0, imin:-1, imax:-1, tun_n:0, tmin:-1, tmax:-1, gmin:-1, gmax:-1,
          drain:4'b0, rd_vld:1'b0, rd:16'h0, both:1'b0, moved:1'b0, stray:1'b0, prog:1'b0,
          timeout:1'b1, ready_after:1'b0};
    ra = row_addr; ca = col_addr; ds = drain_sel;
    for (int c = 1; c <= 4000 && o.timeout; c++) begin
      @(negedge clk);
      if (inj_en && tun_en) o.both = 1'b1;
      if ((inj_en || tun_en) && (row_addr !== ra || col_addr !== ca || drain_sel !== ds)) o.moved = 1'b1;
      ra = row_addr; ca = col_addr; ds = drain_sel;
      o.drain = o.drain | drain_sel;
      if (prog_mode) o.prog = 1'b1;
      if (err && !done) o.stray = 1'b1;
      if (inj_en) ri++;
      else if (ri > 0) begin
        o.inj_n++;
        if (o.imin < 0 || ri < o.imin) o.imin = ri;
        if (ri > o.imax) o.imax = ri;
        ri = 0;
      end
      if (tun_en) rt++;
      else if (rt > 0) begin
        o.tun_n++;
        if (o.tmin < 0 || rt < o.tmin) o.tmin = rt;
        if (rt > o.tmax) o.tmax = rt;
        rt = 0;
      end
      if (inj_en || tun_en) begin
        if (seen && rl > 0) begin
          if (o.gmin < 0 || rl < o.gmin) o.gmin = rl;
          if (rl > o.gmax) o.gmax = rl;
        end
        rl = 0; seen = 1'b1;
      end else if (seen) rl++;
      abort = (abort_at > 0 && inj_en && ri == abort_at);
`ifdef FG_PROG_READBACK_EN
      meas_ack = 1'b0;
      if (meas_req) begin
        req++;
        if (req == MEAS) begin meas_ack = 1'b1; meas_data = 16'hBEEF; end
      end
      if (rd_valid) begin o.rd_vld = 1'b1; o.rd = rd_data; end
`endif
      if (done) begin o.lat = c; o.err = err; o.timeout = 1'b0; end
    end
    abort = 1'b0;
    @(negedge clk);
    o.ready_after = cmd_ready && !done;
  endtask

  task automatic test_reset;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    checks++;
    if ({row_addr, col_addr, drain_sel, prog_mode, inj_en, tun_en, busy, done, err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {row_addr, col_addr, drain_sel, prog_mode, inj_en, tun_en, busy, done, err});
    end
  endtask

  task automatic test_inject;
    obs_t o; exp_t e;
    send(OP_INJECT, 2, 5, 3, 4, 2, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat) begin errors++; $display("FAIL inject_latency got %0d exp %0d timeout %b", o.lat, e.lat, o.timeout); end
    checks++;
    if (o.drain !== 4'b0100) begin errors++; $display("FAIL inject_drain got %b exp 0100", o.drain); end
    checks++;
    if (o.inj_n !== e.inj_n || o.imin !== e.inj_len || o.imax !== e.inj_len) begin
      errors++; $display("FAIL inject_pulses got n=%0d len=%0d..%0d exp n=%0d len=%0d", o.inj_n, o.imin, o.imax, e.inj_n, e.inj_len);
    end
    checks++;
    if (o.gmin !== e.gap || o.gmax !== e.gap) begin errors++; $display("FAIL inject_gap got %0d..%0d exp %0d", o.gmin, o.gmax, e.gap); end
    checks++;
    if ({o.tun_n != 0, o.both, o.moved, o.err, o.stray} !== 5'b0) begin
      errors++; $display("FAIL inject_clean got tun=%0d both=%b moved=%b err=%b stray=%b exp all 0", o.tun_n, o.both, o.moved, o.err, o.stray);
    end
    checks++;
    if ({row_addr, col_addr, o.ready_after} !== {2'd2, 3'd5, 1'b1}) begin
      errors++; $display("FAIL inject_after got row=%0d col=%0d rdy=%b exp 2 5 1", row_addr, col_addr, o.ready_after);
    end
  endtask

  task automatic test_tunnel;
    obs_t o; exp_t e;
    send(OP_TUNNEL, 1, 0, 1, 10, 0, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.err !== 1'b0) begin errors++; $display("FAIL tunnel_done got lat=%0d err=%b exp lat=%0d err=0", o.lat, o.err, e.lat); end
    checks++;
    if (o.tun_n !== 1 || o.tmin !== 10 || o.tmax !== 10 || o.inj_n !== 0 || o.drain !== 4'b0) begin
      errors++; $display("FAIL tunnel_pulse got n=%0d len=%0d inj=%0d drain=%b exp 1 10 0 0000", o.tun_n, o.tmax, o.inj_n, o.drain);
    end
  endtask

  task automatic test_reserved;
    obs_t o; exp_t e;
    send(OP_RSVD, 3, 6, 2, 2, 2, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.err !== 1'b1 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL reserved_done got lat=%0d err=%b rdy=%b exp 1 1 1", o.lat, o.err, o.ready_after);
    end
    checks++;
    if ({o.prog, o.drain, o.inj_n != 0, o.tun_n != 0} !== 7'b0 || {row_addr, col_addr} !== {2'd1, 3'd0}) begin
      errors++; $display("FAIL reserved_quiet got prog=%b drain=%b row=%0d col=%0d exp 0 0000 1 0", o.prog, o.drain, row_addr, col_addr);
    end
  endtask

  task automatic test_zero_fields;
    obs_t o; exp_t e;
    send(OP_INJECT, 3, 1, 0, 0, 0, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.inj_n !== 1 || o.imax !== 1 || o.drain !== 4'b1000) begin
      errors++; $display("FAIL zero_fields got lat=%0d n=%0d len=%0d drain=%b exp %0d 1 1 1000", o.lat, o.inj_n, o.imax, o.drain, e.lat);
    end
    send(OP_INJECT, 0, 2, 2, 3, 0, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.inj_n !== 2 || o.imin !== 3 || o.gmin !== 1 || o.gmax !== 1) begin
      errors++; $display("FAIL gap_zero got lat=%0d n=%0d len=%0d gap=%0d exp %0d 2 3 1", o.lat, o.inj_n, o.imin, o.gmin, e.lat);
    end
  endtask

  task automatic test_abort;
    obs_t o; exp_t e;
    send(OP_INJECT, 1, 4, 1, 100, 0, 2, 1'b0);
    observe(2, o);
    e = exp_q.pop_front();
    checks++;
    if (o.inj_n !== 1 || o.imax !== 2) begin errors++; $display("FAIL abort_pulse got n=%0d len=%0d exp 1 2", o.inj_n, o.imax); end
    checks++;
    if (o.timeout || o.lat !== e.lat || o.err !== 1'b1 || o.stray !== 1'b0) begin
      errors++; $display("FAIL abort_done got lat=%0d err=%b stray=%b exp %0d 1 0", o.lat, o.err, o.stray, e.lat);
    end
    send(OP_TUNNEL, 2, 3, 4, 5, 1, 0, 1'b1);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.err !== 1'b1 || o.tun_n !== 0) begin
      errors++; $display("FAIL abort_accept got lat=%0d err=%b pulses=%0d exp %0d 1 0", o.lat, o.err, o.tun_n, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e;
    send(OP_READ, 0, 7, 3, 3, 3, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.inj_n !== 0 || o.tun_n !== 0 || o.drain !== 4'b0001) begin
      errors++; $display("FAIL read_seq got lat=%0d inj=%0d tun=%0d drain=%b exp %0d 0 0 0001", o.lat, o.inj_n, o.tun_n, o.drain, e.lat);
    end
    checks++;
    if (o.rd_vld !== e.rd_vld || (e.rd_vld && o.rd !== 16'hBEEF)) begin
      errors++; $display("FAIL readback got vld=%b data=%h exp vld=%b data=beef", o.rd_vld, o.rd, e.rd_vld);
    end
    send(OP_TUNNEL, 3, 7, 2, 1, 4, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.tun_n !== 2 || o.gmin !== 4 || o.gmax !== 4) begin
      errors++; $display("FAIL b2b_tunnel got lat=%0d n=%0d gap=%0d exp %0d 2 4", o.lat, o.tun_n, o.gmin, e.lat);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t e;
    send(OP_INJECT, 1, 3, 1, 100, 0, 0, 1'b0);
    for (int c = 0; c < 200 && !inj_en; c++) @(negedge clk);
    checks++;
    if (inj_en !== 1'b1) begin errors++; $display("FAIL rst_mid_reach got inj_en=%b exp 1", inj_en); end
    e = exp_q.pop_back();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({row_addr, col_addr, drain_sel, prog_mode, inj_en, tun_en, busy, done, err, cmd_ready} !== 17'h1) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 00001",
               {row_addr, col_addr, drain_sel, prog_mode, inj_en, tun_en, busy, done, err, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_TUNNEL, 3, 2, 2, 2, 3, 0, 1'b0);
    observe(0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.timeout || o.lat !== e.lat || o.err !== 1'b0 || o.tun_n !== 2 || o.tmax !== 2 || o.gmin !== 3) begin
      errors++; $display("FAIL rst_mid_rerun got lat=%0d err=%b n=%0d len=%0d gap=%0d exp %0d 0 2 2 3", o.lat, o.err, o.tun_n, o.tmax, o.gmin, e.lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'd0; cmd_row = 2'd0; cmd_col = 3'd0;
    cmd_npulse = 8'd0; cmd_pw = 16'd0; cmd_gap = 16'd0;
`ifdef FG_PROG_READBACK_EN
    meas_ack = 1'b0; meas_data = 16'h0;
`endif
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_inject();
    test_tunnel();
    test_reserved();
    test_zero_fields();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
